// File: rtl/y_muldiv.sv
// y_muldiv: iterative unsigned multiply / divide unit.
//
// One operand bit is processed per clock, so every operation takes exactly
// WIDTH cycles in RUN, whatever the op and operand values.
//   op 00 MUL   : low half of a*b
//   op 01 MULHU : high half of a*b
//   op 10 DIVU  : a / b   (b=0 -> all ones)
//   op 11 REMU  : a % b   (b=0 -> a)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request, sampled only while busy=0
//   op         operation select, captured on accept
//   a, b       operands, captured on accept
//   busy       high while an operation is in progress
//   done       one-cycle pulse, z/divByZero valid
//   z          result, held until the next done
//   divByZero  DIVU/REMU with b=0, held with z
//
// state | meaning
// IDLE  | waiting for start; z/divByZero hold the last result
// RUN   | one shift-add or shift-subtract step per clock

module y_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] z,
   output logic             divByZero
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [1:0]           op_q, op_d;
   // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   // MUL: {partial product high, remaining multiplier bits}.
   // DIV: {partial remainder, dividend bits shifting into quotient}.
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     z_q, z_d;
   logic                 dz_q, dz_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_sh;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   step_acc;

   // Shift-add: conditionally add the multiplicand into the high half, then
   // shift the whole product right; the carry lands in the top bit.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});

   // Restoring divide: bring the next dividend bit into the remainder and
   // subtract the divisor only if it fits. With b=0 every subtract fits, which
   // yields quotient all ones and remainder a without any special casing.
   assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_ge   = (div_sh >= {1'b0, opnd_q});

   always_comb begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      if (op_q[1]) begin
         if (div_ge) begin
            step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = {acc_q[2*WIDTH-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      z_d     = z_q;
      dz_d    = dz_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = CNT_LOAD;
               op_d    = op;
               opnd_d  = op[1] ? b : a;
               acc_d   = {{WIDTH{1'b0}}, (op[1] ? a : b)};
            end
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = IDLE;
               done_d  = 1'b1;
               // High half is MULHU product or REMU remainder; low half is
               // MUL product or DIVU quotient.
               z_d     = op_q[0] ? step_acc[2*WIDTH-1:WIDTH] : step_acc[WIDTH-1:0];
               dz_d    = op_q[1] && (opnd_q == {WIDTH{1'b0}});
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         z_q     <= '0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = done_q;
   assign z         = z_q;
   assign divByZero = dz_q;

endmodule
